// File: rtl/fwd_network.sv
// Operand-forwarding network: per-port RAW resolution against producer stages plus a
// stall-aware writeback history. Optional performance counters under FWD_PERF_CNT_EN.
module fwd_network #(
    parameter int XLEN       = 32,
    parameter int N_STAGES   = 4,
    parameter int N_PORTS    = 4,
    parameter int HIST_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       stall,
    input  logic [N_STAGES-1:0]        stg_wen,
    input  logic [N_STAGES*5-1:0]      stg_rd,
    input  logic [N_STAGES*XLEN-1:0]   stg_data,
    input  logic [N_STAGES-1:0]        stg_dvalid,
    input  logic [N_PORTS-1:0]         rd_en,
    input  logic [N_PORTS*5-1:0]       rd_addr,
    output logic [N_PORTS-1:0]         fwd_sel,
    output logic [N_PORTS*XLEN-1:0]    fwd_data,
    output logic [N_PORTS-1:0]         fwd_pending,
    output logic                       hist_ovf,
    output logic [31:0]                perf_hit_cnt,
    output logic [31:0]                perf_pend_cnt
);

    localparam int CNT_W = $clog2(HIST_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIST_DEPTH);

    logic             hist_wen  [HIST_DEPTH];
    logic [4:0]       hist_rd   [HIST_DEPTH];
    logic [XLEN-1:0]  hist_data [HIST_DEPTH];
    logic [CNT_W-1:0] stall_cnt;
    logic             ovf_q;
    logic             ovf_set;
    logic [HIST_DEPTH-1:0] hist_elig;

    // The oldest entry is about to fall off while still eligible.
    assign ovf_set  = stall && (stall_cnt == CNT_MAX) && hist_wen[HIST_DEPTH-1];
    assign hist_ovf = ovf_q | ovf_set;

    always_comb begin
        hist_elig = '0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_elig[k] = (stall_cnt > CNT_W'(k));
        end
    end

    // Candidates are visited from lowest to highest priority so the last hit wins.
    always_comb begin
        fwd_sel     = '0;
        fwd_data    = '0;
        fwd_pending = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (rd_en[p] && (rd_addr[p*5 +: 5] != 5'd0)) begin
                for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                    if (hist_elig[k] && hist_wen[k] && (hist_rd[k] == rd_addr[p*5 +: 5])) begin
                        fwd_sel[p]            = 1'b1;
                        fwd_pending[p]        = 1'b0;
                        fwd_data[p*XLEN +: XLEN] = hist_data[k];
                    end
                end
                for (int i = N_STAGES - 1; i >= 0; i--) begin
                    if (stg_wen[i] && (stg_rd[i*5 +: 5] == rd_addr[p*5 +: 5])) begin
                        fwd_sel[p]            = stg_dvalid[i];
                        fwd_pending[p]        = ~stg_dvalid[i];
                        fwd_data[p*XLEN +: XLEN] = stg_dvalid[i] ? stg_data[i*XLEN +: XLEN] : '0;
                    end
                end
            end
        end
    end

    // History shifts every cycle regardless of stall; eligibility is what tracks the stall.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_wen[k]  <= 1'b0;
                hist_rd[k]   <= '0;
                hist_data[k] <= '0;
            end
            stall_cnt <= '0;
            ovf_q     <= 1'b0;
        end else begin
            hist_wen[0]  <= stg_wen[N_STAGES-1];
            hist_rd[0]   <= stg_rd[(N_STAGES-1)*5 +: 5];
            hist_data[0] <= stg_data[(N_STAGES-1)*XLEN +: XLEN];
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_wen[k]  <= hist_wen[k-1];
                hist_rd[k]   <= hist_rd[k-1];
                hist_data[k] <= hist_data[k-1];
            end
            if (stall) begin
                stall_cnt <= (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
                ovf_q     <= 1'b0;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] hit_inc;

    always_comb begin
        hit_inc = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            hit_inc = hit_inc + {31'd0, fwd_sel[p]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_hit_cnt  <= '0;
            perf_pend_cnt <= '0;
        end else begin
            perf_hit_cnt  <= perf_hit_cnt + hit_inc;
            perf_pend_cnt <= perf_pend_cnt + {31'd0, |fwd_pending};
        end
    end
`else
    assign perf_hit_cnt  = '0;
    assign perf_pend_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_network.sv
// Directed self-checking bench for fwd_network (default parameters).
module tb_fwd_network;

    localparam int XLEN = 32;
    localparam int NS   = 4;
    localparam int NP   = 4;
    localparam int HD   = 2;

    logic              clk = 1'b0;
    logic              nrst;
    logic              stall;
    logic [NS-1:0]     stg_wen;
    logic [NS*5-1:0]   stg_rd;
    logic [NS*XLEN-1:0] stg_data;
    logic [NS-1:0]     stg_dvalid;
    logic [NP-1:0]     rd_en;
    logic [NP*5-1:0]   rd_addr;
    logic [NP-1:0]     fwd_sel;
    logic [NP*XLEN-1:0] fwd_data;
    logic [NP-1:0]     fwd_pending;
    logic              hist_ovf;
    logic [31:0]       perf_hit_cnt;
    logic [31:0]       perf_pend_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fwd_network #(.XLEN(XLEN), .N_STAGES(NS), .N_PORTS(NP), .HIST_DEPTH(HD)) dut (
        .clk(clk), .nrst(nrst), .stall(stall),
        .stg_wen(stg_wen), .stg_rd(stg_rd), .stg_data(stg_data), .stg_dvalid(stg_dvalid),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
        .hist_ovf(hist_ovf), .perf_hit_cnt(perf_hit_cnt), .perf_pend_cnt(perf_pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stg_wen    = '0;
        stg_rd     = '0;
        stg_data   = '0;
        stg_dvalid = '0;
        rd_en      = '0;
        rd_addr    = '0;
    endtask

    task automatic set_stage(input int i, input logic [4:0] rd, input logic [31:0] data, input logic dv);
        stg_wen[i]             = 1'b1;
        stg_rd[i*5 +: 5]       = rd;
        stg_data[i*XLEN +: XLEN] = data;
        stg_dvalid[i]          = dv;
    endtask

    task automatic set_port(input int p, input logic [4:0] addr);
        rd_en[p]           = 1'b1;
        rd_addr[p*5 +: 5]  = addr;
    endtask

    task automatic test_reset();
        nrst = 1'b0; stall = 1'b0; clear_inputs();
        tick(); tick();
        #1;
        total_cnt++;
        if (hist_ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", hist_ovf); else pass_cnt++;
        total_cnt++;
        if (perf_hit_cnt !== 32'd0) $display("[TB] FAIL reset_hit_cnt: got %0d expected 0", perf_hit_cnt); else pass_cnt++;
        set_stage(0, 5'd5, 32'h11, 1'b1);
        set_port(0, 5'd5);
        #1;
        total_cnt++;
        if (fwd_data[31:0] !== 32'h11 || fwd_sel !== 4'b0001)
            $display("[TB] FAIL reset_comb: got sel=%b data=%h expected sel=0001 data=00000011", fwd_sel, fwd_data[31:0]);
        else pass_cnt++;
        tick();
        nrst = 1'b1; clear_inputs();
        tick();
    endtask

    task automatic test_priority();
        clear_inputs();
        set_stage(0, 5'd5, 32'h11, 1'b1);
        set_stage(2, 5'd5, 32'h22, 1'b1);
        set_port(0, 5'd5);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0001 || fwd_data[31:0] !== 32'h11)
            $display("[TB] FAIL prio_young: got sel=%b data=%h expected sel=0001 data=00000011", fwd_sel, fwd_data[31:0]);
        else pass_cnt++;
        stg_wen[0] = 1'b0;
        set_port(2, 5'd5);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0101 || fwd_data[31:0] !== 32'h22 || fwd_data[95:64] !== 32'h22)
            $display("[TB] FAIL prio_older: got sel=%b d0=%h d2=%h expected sel=0101 d0=d2=00000022", fwd_sel, fwd_data[31:0], fwd_data[95:64]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_pending();
        clear_inputs();
        set_stage(0, 5'd7, 32'hDEAD, 1'b0);
        set_stage(1, 5'd7, 32'h33, 1'b1);
        set_port(1, 5'd7);
        rd_addr[3*5 +: 5] = 5'd7;
        #1;
        total_cnt++;
        if (fwd_pending !== 4'b0010 || fwd_sel !== 4'b0000 || fwd_data[63:32] !== 32'h0)
            $display("[TB] FAIL pending: got pend=%b sel=%b data=%h expected pend=0010 sel=0000 data=00000000", fwd_pending, fwd_sel, fwd_data[63:32]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_x0();
        clear_inputs();
        set_stage(1, 5'd0, 32'hFF, 1'b1);
        set_port(0, 5'd0);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0000 || fwd_data !== '0 || fwd_pending !== 4'b0000)
            $display("[TB] FAIL x0: got sel=%b data=%h expected sel=0000 data=0", fwd_sel, fwd_data[31:0]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_history();
        clear_inputs(); stall = 1'b0; tick();
        stall = 1'b1;
        set_stage(3, 5'd9, 32'hAB, 1'b1);
        tick();
        clear_inputs();
        set_port(0, 5'd9);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0001 || fwd_data[31:0] !== 32'hAB)
            $display("[TB] FAIL hist_stall: got sel=%b data=%h expected sel=0001 data=000000ab", fwd_sel, fwd_data[31:0]);
        else pass_cnt++;
        stall = 1'b0; clear_inputs(); tick();
        set_stage(3, 5'd9, 32'hCD, 1'b1);
        tick();
        clear_inputs();
        set_port(0, 5'd9);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0000 || fwd_data[31:0] !== 32'h0)
            $display("[TB] FAIL hist_nostall: got sel=%b data=%h expected sel=0000 data=0", fwd_sel, fwd_data[31:0]);
        else pass_cnt++;
        tick();
        // Two-deep history: x9 in hist[1], x10 in hist[0]; a live stage overrides history.
        stall = 1'b1; clear_inputs();
        set_stage(3, 5'd9, 32'h01, 1'b1);
        tick();
        clear_inputs();
        set_stage(3, 5'd10, 32'h02, 1'b1);
        tick();
        clear_inputs();
        set_port(0, 5'd9);
        set_port(1, 5'd10);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0011 || fwd_data[31:0] !== 32'h01 || fwd_data[63:32] !== 32'h02)
            $display("[TB] FAIL hist_depth: got sel=%b d0=%h d1=%h expected sel=0011 d0=00000001 d1=00000002", fwd_sel, fwd_data[31:0], fwd_data[63:32]);
        else pass_cnt++;
        set_stage(1, 5'd10, 32'h77, 1'b1);
        #1;
        total_cnt++;
        if (fwd_data[63:32] !== 32'h77)
            $display("[TB] FAIL hist_vs_stage: got %h expected 00000077", fwd_data[63:32]);
        else pass_cnt++;
        stall = 1'b0; clear_inputs();
        tick(); tick();
    endtask

    task automatic test_overflow();
        logic exp_ovf [6];
        exp_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        stall = 1'b0; clear_inputs(); tick(); tick();
        for (int n = 0; n < 6; n++) begin
            clear_inputs();
            stall = (n < 4);
            if (n < 4) set_stage(3, 5'(20 + n), 32'(n + 1), 1'b1);
            #1;
            total_cnt++;
            if (hist_ovf !== exp_ovf[n])
                $display("[TB] FAIL ovf_cycle%0d: got %b expected %b", n + 1, hist_ovf, exp_ovf[n]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b0; clear_inputs(); tick();
        stall = 1'b1;
        set_stage(3, 5'd9, 32'h99, 1'b1);
        tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1; clear_inputs();
        set_port(0, 5'd9);
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0000 || hist_ovf !== 1'b0)
            $display("[TB] FAIL reset_mid_stall: got sel=%b ovf=%b expected sel=0000 ovf=0", fwd_sel, hist_ovf);
        else pass_cnt++;
        stall = 1'b0; clear_inputs(); tick();
    endtask

    task automatic test_perf();
        nrst = 1'b0; stall = 1'b0; clear_inputs();
        tick();
        nrst = 1'b1;
        set_stage(0, 5'd5, 32'h5A, 1'b1);
        set_port(0, 5'd5); set_port(1, 5'd5); set_port(2, 5'd5);
        for (int c = 0; c < 10; c++) tick();
`ifdef FWD_PERF_CNT_EN
        total_cnt++;
        if (perf_hit_cnt !== 32'd30) $display("[TB] FAIL perf_hit: got %0d expected 30", perf_hit_cnt); else pass_cnt++;
        stg_dvalid[0] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        total_cnt++;
        if (perf_pend_cnt !== 32'd3 || perf_hit_cnt !== 32'd30)
            $display("[TB] FAIL perf_pend: got pend=%0d hit=%0d expected pend=3 hit=30", perf_pend_cnt, perf_hit_cnt);
        else pass_cnt++;
        nrst = 1'b0;
        tick();
        total_cnt++;
        if (perf_hit_cnt !== 32'd0 || perf_pend_cnt !== 32'd0)
            $display("[TB] FAIL perf_reset: got hit=%0d pend=%0d expected 0/0", perf_hit_cnt, perf_pend_cnt);
        else pass_cnt++;
`else
        total_cnt++;
        if (perf_hit_cnt !== 32'd0 || perf_pend_cnt !== 32'd0)
            $display("[TB] FAIL perf_tied: got hit=%0d pend=%0d expected 0/0", perf_hit_cnt, perf_pend_cnt);
        else pass_cnt++;
`endif
        nrst = 1'b1; clear_inputs();
        tick();
    endtask

    initial begin
        nrst = 1'b0; stall = 1'b0; clear_inputs();
        test_reset();
        test_priority();
        test_pending();
        test_x0();
        test_history();
        test_overflow();
        test_reset_mid_stall();
        test_perf();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
